// File: rtl/pong_text_pkg.sv
// pong_text_pkg
//   Shared definitions for the Pong text overlay:
//   - character codes (CH_BLANK = 0, CH_A..CH_Z = 1..26, 27..31 reserved/blank)
//   - banner animation mode codes
//   - 8x8 glyph bitmap table, one 64-bit word per code.
//     Row 0 (top) sits in bits [63:56]; within a row, bit 7 is the leftmost column.
package pong_text_pkg;

  typedef enum logic [4:0] {
    CH_BLANK = 5'd0,
    CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I,
    CH_J, CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R,
    CH_S, CH_T, CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z
  } char_code_e;

  // Highest code that maps to a real glyph; everything above renders blank.
  localparam int CH_LAST = 26;

  typedef enum logic [1:0] {
    MODE_STATIC     = 2'd0,
    MODE_BLINK      = 2'd1,
    MODE_TYPE       = 2'd2,
    MODE_TYPE_BLINK = 2'd3
  } mode_e;

  localparam int GLYPH_COUNT = 32;

  localparam logic [63:0] GLYPH_TABLE [GLYPH_COUNT] = '{
    64'h0000_0000_0000_0000,  // blank
    64'h1824_4242_7E42_4200,  // A
    64'h7C42_427C_4242_7C00,  // B
    64'h3C42_4040_4042_3C00,  // C
    64'h7844_4242_4244_7800,  // D
    64'h7E40_407C_4040_7E00,  // E
    64'h7E40_407C_4040_4000,  // F
    64'h3C42_404E_4242_3C00,  // G
    64'h4242_427E_4242_4200,  // H
    64'h3E08_0808_0808_3E00,  // I
    64'h1E04_0404_4444_3800,  // J
    64'h4448_5060_5048_4400,  // K
    64'h4040_4040_4040_7E00,  // L
    64'h4266_5A5A_4242_4200,  // M
    64'h4262_524A_4642_4200,  // N
    64'h3C42_4242_4242_3C00,  // O
    64'h7C42_427C_4040_4000,  // P
    64'h3C42_4242_4A44_3A00,  // Q
    64'h7C42_427C_4844_4200,  // R
    64'h3C42_403C_0242_3C00,  // S
    64'h7F08_0808_0808_0800,  // T
    64'h4242_4242_4242_3C00,  // U
    64'h4242_4242_2424_1800,  // V
    64'h4242_425A_5A66_4200,  // W
    64'h4224_1818_1824_4200,  // X
    64'h4122_1408_0808_0800,  // Y
    64'h7E04_0810_2040_7E00,  // Z
    64'h0000_0000_0000_0000,  // 27 reserved
    64'h0000_0000_0000_0000,  // 28 reserved
    64'h0000_0000_0000_0000,  // 29 reserved
    64'h0000_0000_0000_0000,  // 30 reserved
    64'h0000_0000_0000_0000   // 31 reserved
  };

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom
//   Combinational glyph lookup: (code, row, col) -> pixel bit.
//   Ports:
//     i_code  character code (CODE_W bits)
//     i_row   glyph row 0..7, 0 = top
//     i_col   glyph column 0..7, 0 = leftmost
//     o_bit   1 when the glyph pixel is set; always 0 for blank/reserved codes
module glyph_rom
  import pong_text_pkg::*;
#(
  parameter int CODE_W = 5
) (
  input  logic [CODE_W-1:0] i_code,
  input  logic [2:0]        i_row,
  input  logic [2:0]        i_col,
  output logic              o_bit
);

  logic        w_blank;
  logic [4:0]  w_idx;
  logic [63:0] w_glyph;

  assign w_blank = (i_code == '0) || (i_code > CODE_W'(CH_LAST));
  // Blank codes are steered to entry 0 so the table index never leaves range.
  assign w_idx   = w_blank ? 5'd0 : 5'(i_code);
  assign w_glyph = GLYPH_TABLE[w_idx];
  // Row r occupies byte (7-r), column c is bit (7-c) of that byte, so the
  // flat bit index is simply {~row, ~col}.
  assign o_bit   = ~w_blank & w_glyph[{~i_row, ~i_col}];

endmodule

// File: rtl/text_banner.sv
// text_banner
//   Draws a run of N_CHARS scaled 8x8 glyphs at (start_x, start_y) as the VGA
//   scan passes over it, with optional blink and typewriter-reveal animation.
//   Ports:
//     clk, rst_n  pixel clock, asynchronous active-low reset
//     frame_tick  one-cycle pulse per frame, advances animation counters
//     start       one-cycle pulse, restarts animation state
//     mode        0 static, 1 blink, 2 typewriter, 3 typewriter then blink
//     start_x/y   banner top-left corner
//     x/y         current scan position
//     text        slot k at bits [k*CODE_W +: CODE_W], slot 0 leftmost
//     pixel       banner pixel lit, 2 cycles after x/y
//     done        typewriter reveal complete
module text_banner
  import pong_text_pkg::*;
#(
  parameter int N_CHARS       = 8,
  parameter int CODE_W        = 5,
  parameter int COORD_W       = 10,
  parameter int SCALE_LOG2    = 2,
  parameter int GAP           = 4,
  parameter int BLINK_FRAMES  = 30,
  parameter int REVEAL_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [COORD_W-1:0]          start_x,
  input  logic [COORD_W-1:0]          start_y,
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic [N_CHARS*CODE_W-1:0]   text,
  output logic                        pixel,
  output logic                        done
);

  localparam int G      = 8 << SCALE_LOG2;
  localparam int PITCH  = G + GAP;
  localparam int BOX_W  = N_CHARS * PITCH - GAP;
  localparam int W      = COORD_W + 1;
  localparam int SLOT_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int RV_W   = $clog2(N_CHARS + 1);
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int RCNT_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  // ---------------------------------------------------------------- animation
  logic [RV_W-1:0]   r_rv;
  logic [RCNT_W-1:0] r_rev_cnt;
  logic [BCNT_W-1:0] r_blink_cnt;
  logic              r_blink_phase;
  logic              w_tick;
  logic              w_done;
  logic              w_blink_hold;

  // A start in the same cycle as a tick swallows the tick.
  assign w_tick       = frame_tick & ~start;
  assign w_done       = (r_rv == RV_W'(N_CHARS));
  assign w_blink_hold = (mode == MODE_TYPE_BLINK) && !w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv      <= '0;
      r_rev_cnt <= '0;
    end else if (start) begin
      r_rv      <= '0;
      r_rev_cnt <= '0;
    end else if (w_tick) begin
      if (r_rev_cnt == RCNT_W'(REVEAL_FRAMES - 1)) begin
        r_rev_cnt <= '0;
        if (!w_done) r_rv <= r_rv + 1'b1;
      end else begin
        r_rev_cnt <= r_rev_cnt + 1'b1;
      end
    end
  end

  // In mode 3 blinking must begin from a fresh half-period once the reveal
  // completes, so the blink state is pinned until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (start || w_blink_hold) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_tick) begin
      if (r_blink_cnt == BCNT_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [W-1:0]      w_dx;
  logic [W-1:0]      w_dy;
  logic              w_in_box;
  logic [N_CHARS-1:0] w_ge;
  logic [W-1:0]      w_off_k [N_CHARS];
  logic [SLOT_W-1:0] w_slot;
  logic [W-1:0]      w_off;
  logic              w_in_glyph;
  logic              w_visible;
  logic [CODE_W-1:0] w_code;

  // Extra top bit: a negative difference (scan left of / above the origin)
  // shows up as the MSB being set instead of wrapping into the box.
  assign w_dx = {1'b0, x} - {1'b0, start_x};
  assign w_dy = {1'b0, y} - {1'b0, start_y};

  assign w_in_box = ~w_dx[W-1] && (w_dx < W'(BOX_W)) &&
                    ~w_dy[W-1] && (w_dy < W'(G));

  // Slot boundaries are constants, so each slot gets its own comparator and
  // subtractor; the highest boundary passed selects the slot.
  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_slot
    assign w_ge[gi]    = (w_dx >= W'(gi * PITCH));
    assign w_off_k[gi] = w_dx - W'(gi * PITCH);
  end

  always_comb begin
    w_slot = '0;
    w_off  = w_off_k[0];
    for (int k = 1; k < N_CHARS; k++) begin
      if (w_ge[k]) begin
        w_slot = SLOT_W'(k);
        w_off  = w_off_k[k];
      end
    end
  end

  assign w_in_glyph = w_in_box && (w_off < W'(G));
  assign w_code     = text[w_slot*CODE_W +: CODE_W];

  always_comb begin
    w_visible = 1'b1;
    case (mode)
      MODE_STATIC:     w_visible = 1'b1;
      MODE_BLINK:      w_visible = r_blink_phase;
      MODE_TYPE:       w_visible = (RV_W'(w_slot) < r_rv);
      MODE_TYPE_BLINK: w_visible = w_done ? r_blink_phase : (RV_W'(w_slot) < r_rv);
      default:         w_visible = 1'b1;
    endcase
  end

  logic              r_lit_en;
  logic [CODE_W-1:0] r_code;
  logic [2:0]        r_row;
  logic [2:0]        r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lit_en <= 1'b0;
      r_code   <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      r_lit_en <= w_in_glyph && w_visible;
      r_code   <= w_code;
      r_row    <= w_dy[SCALE_LOG2 +: 3];
      r_col    <= w_off[SCALE_LOG2 +: 3];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic w_rom_bit;
  logic r_pixel;

  glyph_rom #(
    .CODE_W (CODE_W)
  ) u_glyph_rom (
    .i_code (r_code),
    .i_row  (r_row),
    .i_col  (r_col),
    .o_bit  (w_rom_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel <= 1'b0;
    else        r_pixel <= w_rom_bit & r_lit_en;
  end

  assign pixel = r_pixel;
  assign done  = w_done;

endmodule
